// File: rtl/vmem_pkg.sv
// vmem_pkg: shared constants, FSM state type and address packing for the
// 640x480 RGB888 video memory. Used by vmem_arbiter and vga_ctrl.
package vmem_pkg;

  localparam int H_BITS   = 10;
  localparam int V_BITS   = 9;
  localparam int A_BITS   = H_BITS + V_BITS;
  localparam int DATA_W   = 24;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [DATA_W-1:0] CLEAR_COLOR = 24'h000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } vmem_state_e;

  // Memory address layout: column in the upper bits, row in the lower bits.
  function automatic logic [A_BITS-1:0] pack_addr(input logic [H_BITS-1:0] h,
                                                  input logic [V_BITS-1:0] v);
    return {h, v};
  endfunction

endpackage

// File: rtl/vmem_arbiter_if.sv
// vmem_arbiter_if: host pixel-write channel (valid/ready).
//   wr_valid  host -> arbiter  write request
//   wr_ready  arbiter -> host  write accepted this cycle
//   wr_h/wr_v host -> arbiter  pixel column / row
//   wr_data   host -> arbiter  RGB888 pixel
// Modports: master = host side, slave = arbiter side.
interface vmem_arbiter_if;
  import vmem_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [H_BITS-1:0] wr_h;
  logic [V_BITS-1:0] wr_v;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, wr_h, wr_v, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_h, wr_v, wr_data, output wr_ready);
endinterface

// File: rtl/vmem_clear_seq.sv
// vmem_clear_seq: pixel walker for the clear-screen sequence.
//   clk, resetn  clock / async active-low reset
//   start        zero both counters
//   run          sequencer is in its clear phase
//   stall        memory port taken by the scan reader; hold counters
//   h, v         current pixel (v is the inner index)
//   last         current pixel is the final one of the frame
module vmem_clear_seq
  import vmem_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int V_ACT = V_ACTIVE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              run,
  input  logic              stall,
  output logic [H_BITS-1:0] h,
  output logic [V_BITS-1:0] v,
  output logic              last
);

  logic v_end;

  assign v_end = (v == V_BITS'(V_ACT - 1));
  assign last  = v_end && (h == H_BITS'(H_ACT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h <= '0;
      v <= '0;
    end else if (start) begin
      h <= '0;
      v <= '0;
    end else if (run && !stall) begin
      if (last) begin
        h <= '0;
        v <= '0;
      end else if (v_end) begin
        v <= '0;
        h <= h + 1'b1;
      end else begin
        v <= v + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: single-port frame-RAM arbiter with clear-screen sequencer.
// Priority every cycle: scan read > clear write > host write.
//   clk, resetn          clock / async active-low reset
//   vga_valid,h/v_addr   scan read request and pixel address
//   vga_data             read pixel, one cycle after the request (0 otherwise)
//   wr                   host write channel (vmem_arbiter_if.slave)
//   clr_start            one-cycle clear request (IDLE only)
//   clr_busy, clr_done   clear in progress / completion pulse
//   drop_cnt             saturating count of out-of-range host writes
//   mem_*                frame RAM port, combinational from state and inputs
//
// state | meaning
// IDLE  | port free for host writes, waiting for clr_start
// CLEAR | writing the clear colour pixel by pixel, stalled by scan reads
// DONE  | one-cycle clr_done pulse
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int                H_ACT     = H_ACTIVE,
  parameter int                V_ACT     = V_ACTIVE,
  parameter logic [DATA_W-1:0] CLR_COLOR = CLEAR_COLOR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vga_valid,
  input  logic [H_BITS-1:0] h_addr,
  input  logic [V_BITS-1:0] v_addr,
  output logic [DATA_W-1:0] vga_data,
  vmem_arbiter_if.slave     wr,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [7:0]        drop_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [A_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  vmem_state_e       state_q, state_d;
  logic              rd_q;
  logic [7:0]        drop_q;
  logic              ready;
  logic              wr_fire;
  logic              in_range;
  logic [H_BITS-1:0] seq_h;
  logic [V_BITS-1:0] seq_v;
  logic              seq_last;

  vmem_clear_seq #(
    .H_ACT(H_ACT),
    .V_ACT(V_ACT)
  ) u_seq (
    .clk   (clk),
    .resetn(resetn),
    .start (state_q == IDLE && clr_start),
    .run   (state_q == CLEAR),
    .stall (vga_valid),
    .h     (seq_h),
    .v     (seq_v),
    .last  (seq_last)
  );

  assign ready       = !vga_valid && (state_q == IDLE);
  assign wr.wr_ready = ready;
  assign wr_fire     = wr.wr_valid && ready;
  assign in_range    = (wr.wr_h < H_BITS'(H_ACT)) && (wr.wr_v < V_BITS'(V_ACT));

  assign clr_busy = (state_q != IDLE);
  assign clr_done = (state_q == DONE);
  assign drop_cnt = drop_q;
  assign vga_data = rd_q ? mem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= vga_valid;
      if (wr_fire && !in_range && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_start) state_d = CLEAR;
      CLEAR:   if (!vga_valid && seq_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (vga_valid) begin
      mem_en   = 1'b1;
      mem_addr = pack_addr(h_addr, v_addr);
    end else if (state_q == CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = pack_addr(seq_h, seq_v);
      mem_wdata = CLR_COLOR;
    end else if (wr_fire && in_range) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = pack_addr(wr.wr_h, wr.wr_v);
      mem_wdata = wr.wr_data;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: scoreboard bench for vmem_arbiter on a reduced 20x12
// frame so full clears stay short. A behavioural model (pixel index, phase,
// drop count) predicts each cycle's memory access and control outputs; a
// negedge monitor pops and compares them.
module tb_vmem_arbiter;
  import vmem_pkg::*;

  localparam int HA   = 20;
  localparam int VA   = 12;
  localparam int NPIX = HA * VA;
  localparam logic [DATA_W-1:0] CCOL = 24'h5A3C1E;

  typedef struct packed {
    logic              we;
    logic [A_BITS-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       done;
    logic [7:0] drops;
  } ctl_exp_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              vga_valid = 1'b0;
  logic [H_BITS-1:0] h_addr = '0;
  logic [V_BITS-1:0] v_addr = '0;
  logic [DATA_W-1:0] vga_data;
  logic              clr_start = 1'b0;
  logic              clr_busy, clr_done;
  logic [7:0]        drop_cnt;
  logic              mem_en, mem_we;
  logic [A_BITS-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  vmem_arbiter_if wif();

  vmem_arbiter #(.H_ACT(HA), .V_ACT(VA), .CLR_COLOR(CCOL)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .vga_valid(vga_valid),
    .h_addr   (h_addr),
    .v_addr   (v_addr),
    .vga_data (vga_data),
    .wr       (wif),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .drop_cnt (drop_cnt),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mem_exp_t          mem_q[$];
  ctl_exp_t          ctl_q[$];
  logic [DATA_W-1:0] vga_q[$];

  // reference model: 0 idle, 1 clearing, 2 done pulse
  int   ph = 0;
  int   idx = 0;
  int   drops = 0;
  logic prev_vv = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_empty(string name);
    total++;
    bad++;
    $display("FAIL %s: DUT output with no expectation queued at %0t", name, $time);
  endfunction

  // one clock cycle of stimulus plus model prediction
  task automatic step(input logic vv, input logic [H_BITS-1:0] ha, input logic [V_BITS-1:0] va,
                      input logic cs, input logic wv, input logic [H_BITS-1:0] wh,
                      input logic [V_BITS-1:0] wvr, input logic [DATA_W-1:0] wd,
                      output logic acc);
    mem_exp_t e;
    ctl_exp_t c;
    int nph;
    logic rdy;
    @(posedge clk);
    #1;
    vga_valid     = vv;
    h_addr        = ha;
    v_addr        = va;
    clr_start     = cs;
    wif.wr_valid  = wv;
    wif.wr_h      = wh;
    wif.wr_v      = wvr;
    wif.wr_data   = wd;
    mem_rdata     = DATA_W'($urandom);

    rdy     = !vv && (ph == 0);
    acc     = wv && rdy;
    c.rdy   = rdy;
    c.busy  = (ph != 0);
    c.done  = (ph == 2);
    c.drops = 8'(drops);
    ctl_q.push_back(c);
    vga_q.push_back(prev_vv ? mem_rdata : '0);

    nph = ph;
    if (vv) begin
      e.we = 1'b0; e.addr = {ha, va}; e.wdata = '0;
      mem_q.push_back(e);
    end else if (ph == 1) begin
      e.we = 1'b1;
      e.addr = {H_BITS'(idx / VA), V_BITS'(idx % VA)};
      e.wdata = CCOL;
      mem_q.push_back(e);
      idx++;
      if (idx == NPIX) nph = 2;
    end else if (acc) begin
      if (int'(wh) < HA && int'(wvr) < VA) begin
        e.we = 1'b1; e.addr = {wh, wvr}; e.wdata = wd;
        mem_q.push_back(e);
      end else if (drops < 255) begin
        drops++;
      end
    end
    if (ph == 0 && cs) begin
      nph = 1;
      idx = 0;
    end else if (ph == 2) begin
      nph = 0;
    end
    ph      = nph;
    prev_vv = vv;
    chk_en  = 1'b1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, '0, acc);
  endtask

  task automatic do_reset(input bit full_check);
    @(negedge clk);
    #1;
    chk_en       = 1'b0;
    vga_valid    = 1'b0;
    clr_start    = 1'b0;
    wif.wr_valid = 1'b0;
    resetn       = 1'b0;
    #1;
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_mem_en", mem_en, 0);
    if (full_check) begin
      chk("rst_vga_data", vga_data, 0);
      chk("rst_wr_ready", wif.wr_ready, 1);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end
    ph = 0; idx = 0; drops = 0; prev_vv = 1'b0;
    mem_q.delete(); ctl_q.delete(); vga_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ctl_exp_t c;
      mem_exp_t e;
      if (ctl_q.size() == 0) fail_empty("ctl");
      else begin
        c = ctl_q.pop_front();
        chk("wr_ready", wif.wr_ready, c.rdy);
        chk("clr_busy", clr_busy, c.busy);
        chk("clr_done", clr_done, c.done);
        chk("drop_cnt", drop_cnt, c.drops);
      end
      if (vga_q.size() == 0) fail_empty("vga_data");
      else chk("vga_data", vga_data, vga_q.pop_front());
      if (mem_en) begin
        if (mem_q.size() == 0) fail_empty("mem_access");
        else begin
          e = mem_q.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (mem_q.size() != 0) begin
        total++;
        bad++;
        $display("FAIL mem_missing: got mem_en=%0b expected %0d pending access", mem_en, mem_q.size());
        mem_q.delete();
      end
    end
  end

  initial begin
    logic acc;
    logic pend;
    logic [H_BITS-1:0] ph_h;
    logic [V_BITS-1:0] ph_v;
    logic [DATA_W-1:0] ph_d;

    wif.wr_valid = 1'b0;
    wif.wr_h = '0;
    wif.wr_v = '0;
    wif.wr_data = '0;

    do_reset(1);
    idle(4);

    // scan read at (5,7)
    step(1, 10'd5, 9'd7, 0, 0, '0, '0, '0, acc);
    #1;
    chk("read_addr", mem_addr, 19'h00A07);
    chk("read_we", mem_we, 0);
    chk("read_ready", wif.wr_ready, 0);
    idle(1);

    // corner pixel write in blanking
    step(0, '0, '0, 0, 1, H_BITS'(HA - 1), V_BITS'(VA - 1), 24'hFF0000, acc);
    #1;
    chk("wr_corner_we", mem_we, 1);
    chk("wr_corner_addr", mem_addr, {H_BITS'(HA - 1), V_BITS'(VA - 1)});

    // write held across three scan cycles
    for (int i = 0; i < 3; i++)
      step(1, H_BITS'(i), V_BITS'(i), 0, 1, 10'd3, 9'd4, 24'h00FF00, acc);
    step(0, '0, '0, 0, 1, 10'd3, 9'd4, 24'h00FF00, acc);
    chk("stall_accept", acc, 1);

    // out-of-range column
    step(0, '0, '0, 0, 1, H_BITS'(HA), 9'd0, 24'h0000FF, acc);
    #1;
    chk("oor_mem_en", mem_en, 0);
    idle(1);
    chk("oor_drop", drop_cnt, 1);

    // full clear, no scan traffic
    step(0, '0, '0, 1, 0, '0, '0, '0, acc);
    idle(NPIX + 3);

    // clear with scan reads every other cycle
    step(0, '0, '0, 1, 0, '0, '0, '0, acc);
    for (int i = 0; i < 2 * NPIX + 4; i++)
      step(logic'(i % 2 == 0), H_BITS'($urandom), V_BITS'($urandom), 0, 0, '0, '0, '0, acc);
    idle(2);

    // clear request coinciding with a host write
    step(0, '0, '0, 1, 1, 10'd1, 9'd2, 24'hABCDEF, acc);
    chk("same_cycle_accept", acc, 1);
    idle(NPIX + 3);

    // randomized traffic
    pend = 1'b0;
    ph_h = '0; ph_v = '0; ph_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        ph_h = H_BITS'($urandom_range(0, HA + 3));
        ph_v = V_BITS'($urandom_range(0, VA + 2));
        ph_d = DATA_W'($urandom);
        pend = 1'b1;
      end
      step(logic'($urandom_range(0, 2) == 0), H_BITS'($urandom), V_BITS'($urandom),
           logic'($urandom_range(0, 399) == 0), pend, ph_h, ph_v, ph_d, acc);
      if (acc) pend = 1'b0;
    end
    idle(2 * NPIX + 4);

    // drop counter saturation
    for (int i = 0; i < 300; i++)
      step(0, '0, '0, 0, 1, 10'd0, V_BITS'(VA + (i % 5)), 24'h111111, acc);
    idle(1);
    chk("drop_sat", drop_cnt, 8'hFF);

    // reset after 100 clear writes
    step(0, '0, '0, 1, 0, '0, '0, '0, acc);
    idle(100);
    do_reset(0);
    idle(20);
    chk("post_reset_busy", clr_busy, 0);
    step(0, '0, '0, 1, 0, '0, '0, '0, acc);
    idle(NPIX + 3);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    chk("final_queue_empty", 32'(mem_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmem_arbiter.md
# vmem_arbiter

Single-port arbiter and clear sequencer for the 640x480 24-bit video memory behind `vga_ctrl`. Shares the one memory port between the VGA scan reader (absolute priority), a hardware clear-screen sequencer, and a host writer (keyboard/terminal logic) using a valid/ready handshake. Sits between `vga_ctrl`, the host write source, and the frame RAM.

## Interface
- `H_BITS`, 10, horizontal address width
- `V_BITS`, 9, vertical address width
- `DATA_W`, 24, pixel width (RGB888)
- `H_ACTIVE`, 640, visible columns
- `V_ACTIVE`, 480, visible rows
- `CLEAR_COLOR`, 24'h000000, pixel value written by a clear

Ports:
- `clk`  in  1  single clock
- `resetn`  in  1  asynchronous, active-low reset
- `vga_valid`  in  1  scan reader needs the port this cycle (display-active)
- `h_addr`  in  H_BITS  scan column
- `v_addr`  in  V_BITS  scan row
- `vga_data`  out  DATA_W  read pixel, 1-cycle latency
- `wr_valid`  in  1  host write request
- `wr_ready`  out  1  host write accepted this cycle
- `wr_h`  in  H_BITS  write column
- `wr_v`  in  V_BITS  write row
- `wr_data`  in  DATA_W  write pixel
- `clr_start`  in  1  one-cycle clear request
- `clr_busy`  out  1  clear in progress
- `clr_done`  out  1  one-cycle pulse when the clear completes
- `drop_cnt`  out  8  saturating count of out-of-range host writes
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  H_BITS+V_BITS  address = {h, v}
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  synchronous read data, valid the cycle after `mem_en` with `!mem_we`

## Operation
- Port priority, evaluated every cycle: scan read > clear write > host write.
- Read: when `vga_valid`=1, drive `mem_en`=1, `mem_we`=0, `mem_addr`={h_addr,v_addr}. Register `rd_q`<=`vga_valid`. `vga_data` = `rd_q` ? `mem_rdata` : 0.
- FSM states:
  - IDLE: on `clr_start`, go to CLEAR with counters h=0, v=0.
  - CLEAR: each cycle with `vga_valid`=0, write CLEAR_COLOR at {h,v}. v is the inner index: when v=V_ACTIVE-1, set v=0 and h+=1. The write at (H_ACTIVE-1, V_ACTIVE-1) moves the FSM to DONE. Cycles with `vga_valid`=1 stall the sequence with the counters held.
  - DONE: `clr_done`=1 for one cycle, then IDLE.
- `clr_busy`=1 in CLEAR and DONE. `clr_start` is ignored outside IDLE.
- Host writes:
  - `wr_ready` = !`vga_valid` && state==IDLE (combinational).
  - A transfer occurs when `wr_valid`&&`wr_ready`.
  - In range (`wr_h`<H_ACTIVE and `wr_v`<V_ACTIVE): `mem_en`=`mem_we`=1 in the same cycle, with address {wr_h,wr_v} and data `wr_data`.
  - Out of range: the handshake completes with no memory access, and `drop_cnt` increments, saturating at 255.
  - The host holds its payload stable while `wr_valid`&&!`wr_ready`.
- `clr_start` and `wr_valid` in the same IDLE cycle with `vga_valid`=0: the write is accepted in that cycle, and CLEAR begins on the next cycle.
- Reset mid-clear: the clear aborts with no `clr_done`, and the counters return to 0.

## Timing
- Reset values: `vga_data`=0, `wr_ready`=!`vga_valid`, `clr_busy`=0, `clr_done`=0, `drop_cnt`=0, `mem_en`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Read latency is 1 cycle, from address to `vga_data`.
- Host write latency is 0 cycles: the memory write happens in the acceptance cycle.
- Clear timing: `clr_start` is sampled at edge 0, and writes run in cycles 1..N.
  - N = 307200 plus the number of stall cycles.
  - `clr_done` asserts in cycle N+1.
- All memory-side outputs are combinational from state/counters and inputs. All state is flopped on `clk`, with asynchronous clear on `resetn` low.

## Structure
- Package `vmem_pkg`: H_BITS, V_BITS, DATA_W, H_ACTIVE, V_ACTIVE, the FSM state enum {IDLE, CLEAR, DONE}, and the address-pack function {h,v}. `vmem` and `vga_ctrl` share this package.
- One sub-module, `vmem_clear_seq`: the h/v counters plus the last-pixel detect, with a stall input.

## Test plan
- Reset: hold `resetn`=0 while `vga_valid`=0 -> all outputs at their reset values and `wr_ready`=1. Release reset -> no memory access until a request arrives.
- Read: `vga_valid`=1, h=5, v=7 -> `mem_addr`=19'h00A07, `mem_we`=0, `wr_ready`=0. Next cycle, `vga_data` equals `mem_rdata`.
- Write in blank: `wr_h`=639, `wr_v`=479, `wr_data`=24'hFF0000 -> same cycle `mem_we`=1, `mem_addr`=19'h4FFDF.
- Write stall: `wr_valid` held while `vga_valid`=1 for 3 cycles -> `wr_ready`=0 and no `mem_we`. The write is accepted in the first cycle `vga_valid`=0.
- Out of range: `wr_h`=640 -> handshake completes, `mem_en`=0, `drop_cnt`=1.
- Clear:
  - `vga_valid`=0 throughout -> 307200 writes of CLEAR_COLOR, `clr_done` at cycle 307201.
  - `vga_valid` toggling every cycle -> 614400 write/stall cycles, ending in `clr_done`.
  - `resetn` pulsed after write 1000 -> `clr_busy`=0 and no `clr_done`.
